lc3b_divider: RTL and testbench

- Multi-cycle iterative integer divider for the LC-3b datapath. It is the sequential counterpart to the single-cycle ALU and handles the operation the ALU cannot do in one cycle.
- Accepts a dividend/divisor pair over a valid/ready request handshake and returns quotient and remainder over a valid/ready response handshake.
- Sits beside the ALU and is driven by the control FSM, which stalls on busy.
- Uses a restoring shift-subtract algorithm, one quotient bit per cycle.

---
 rtl/lc3b_divider.sv | 198 +++++++++++++++++++
 tb/tb_lc3b_divider.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_divider.sv
// LC-3b iterative restoring divider, one quotient bit per cycle.
// Define LC3B_DIV_SIGNED_EN to honour is_signed; otherwise all ops are unsigned.
module lc3b_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign accept   = req_valid && req_ready;
  assign dvs_zero = (divisor == '0);

`ifdef LC3B_DIV_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  always_comb begin
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (accept) begin
      q_neg_d = dvd_neg ^ dvs_neg;
      r_neg_d = dvd_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = dvs_zero ? DONE : ITER;
        end
      end
      ITER: begin
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    resp_valid = (state_q == DONE);
  end

  always_comb begin
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d = '0;
          quo_d = dvd_mag;
          dvs_d = dvs_mag;
          cnt_d = CW'(WIDTH);
          if (dvs_zero) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
        end
      end
      ITER: begin
        rem_d = diff[WIDTH] ? shifted[WIDTH-1:0]
                            : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
`ifdef LC3B_DIV_SIGNED_EN
        quotient_d  = q_neg_q ? -quo_q : quo_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
`else
        quotient_d  = quo_q;
        remainder_d = rem_q;
`endif
        dbz_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_lc3b_divider.sv
// Directed bench for lc3b_divider.
// Expected signed results follow LC3B_DIV_SIGNED_EN.
module tb_lc3b_divider;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        is_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int checks;
  int failures;

`ifdef LC3B_DIV_SIGNED_EN
  localparam logic [15:0] EXP_NEG_Q = 16'hFFFD;
  localparam logic [15:0] EXP_NEG_R = 16'hFFFF;
  localparam logic [15:0] EXP_OVF_Q = 16'h8000;
  localparam logic [15:0] EXP_OVF_R = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG_Q = 16'h7FFC;
  localparam logic [15:0] EXP_NEG_R = 16'h0001;
  localparam logic [15:0] EXP_OVF_Q = 16'h0000;
  localparam logic [15:0] EXP_OVF_R = 16'h8000;
`endif

  lc3b_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request across an edge; returns at cycle T+1 with
  // scrambled operands to show they are ignored after accept.
  task automatic issue(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic s);
    req_valid = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    dividend  = 16'hA5A5;
    divisor   = 16'h0003;
    is_signed = ~s;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) lat = -1;
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0
        || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctl got v=%b b=%b r=%b exp 0 0 1",
               resp_valid, busy, req_ready);
    end
    checks++;
    if (quotient !== 16'h0 || remainder !== 16'h0
        || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got q=%h r=%h z=%b exp 0 0 0",
               quotient, remainder, div_by_zero);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got r=%b b=%b exp 1 0",
               req_ready, busy);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    issue(16'd100, 16'd7, 1'b0);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0
        || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL uns_busy got b=%b r=%b v=%b exp 1 0 0",
               busy, req_ready, resp_valid);
    end
    wait_resp(lat);
    checks++;
    if (lat !== 18) begin
      failures++;
      $display("FAIL uns_latency got %0d exp 18", lat);
    end
    checks++;
    if (quotient !== 16'h000E || remainder !== 16'h0002
        || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL uns_100_7 got q=%h r=%h z=%b exp 000e 0002 0",
               quotient, remainder, div_by_zero);
    end
    drain();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0
        || quotient !== 16'h000E) begin
      failures++;
      $display("FAIL uns_idle got r=%b v=%b q=%h exp 1 0 000e",
               req_ready, resp_valid, quotient);
    end
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat !== 18 || quotient !== 16'hFFFF
        || remainder !== 16'h0000) begin
      failures++;
      $display("FAIL uns_ffff_1 got lat=%0d q=%h r=%h exp 18 ffff 0000",
               lat, quotient, remainder);
    end
    drain();
  endtask

  task automatic test_signed();
    int lat;
    issue(16'hFFF9, 16'h0002, 1'b1);
    wait_resp(lat);
    checks++;
    if (lat !== 18 || quotient !== EXP_NEG_Q
        || remainder !== EXP_NEG_R) begin
      failures++;
      $display("FAIL sgn_m7_2 got lat=%0d q=%h r=%h exp 18 %h %h",
               lat, quotient, remainder, EXP_NEG_Q, EXP_NEG_R);
    end
    drain();
    issue(16'h8000, 16'hFFFF, 1'b1);
    wait_resp(lat);
    checks++;
    if (quotient !== EXP_OVF_Q || remainder !== EXP_OVF_R
        || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL sgn_ovf got q=%h r=%h z=%b exp %h %h 0",
               quotient, remainder, div_by_zero,
               EXP_OVF_Q, EXP_OVF_R);
    end
    drain();
  endtask

  task automatic test_div_zero();
    int lat;
    issue(16'h1234, 16'h0000, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL dbz_latency got %0d exp 1", lat);
    end
    checks++;
    if (quotient !== 16'hFFFF || remainder !== 16'h1234
        || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dbz_out got q=%h r=%h z=%b exp ffff 1234 1",
               quotient, remainder, div_by_zero);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue(16'd200, 16'd9, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat !== 18 || quotient !== 16'd22 || remainder !== 16'd2
        || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL bp_200_9 got lat=%0d q=%h r=%h z=%b exp 18 0016 0002 0",
               lat, quotient, remainder, div_by_zero);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      dividend  = 16'd50;
      divisor   = 16'd5;
      is_signed = 1'b0;
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0
          || quotient !== 16'd22 || remainder !== 16'd2)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_hold got %0d bad cycles exp 0", bad);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0
        || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got r=%b v=%b b=%b exp 1 0 0",
               req_ready, resp_valid, busy);
    end
    issue(16'd50, 16'd5, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat !== 18 || quotient !== 16'd10 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL bp_50_5 got lat=%0d q=%h r=%h exp 18 000a 0000",
               lat, quotient, remainder);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(16'd1000, 16'd3, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1
        || quotient !== 16'h0 || remainder !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset got v=%b b=%b r=%b q=%h r=%h exp 0 0 1 0 0",
               resp_valid, busy, req_ready, quotient, remainder);
    end
    issue(16'd9, 16'd4, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat !== 18 || quotient !== 16'd2 || remainder !== 16'd1) begin
      failures++;
      $display("FAIL mid_9_4 got lat=%0d q=%h r=%h exp 18 0002 0001",
               lat, quotient, remainder);
    end
    drain();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    dividend   = 16'h0;
    divisor    = 16'h0;
    is_signed  = 1'b0;
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
